remodel_sram_stream_reader: RTL

- Initiator for the single-port SRAM request interface (req/we/addr/wdata/be in, fixed-latency rdata out).
- Reads a strided block of words from the SRAM and presents them in order on a valid/ready output stream.
- Uses credit-based request throttling and an internal FIFO so no returning read data is lost under downstream backpressure.
- Sits between a remodel SRAM port and a streaming consumer such as an accelerator operand feeder.

---
 rtl/remodel_sram_stream_reader.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/remodel_sram_stream_reader.sv
// Strided SRAM block reader: issues credit-limited reads and streams the returned words in order.
// A small FIFO absorbs returning data under backpressure; when it is empty, data falls through with no extra cycle.
module remodel_sram_stream_reader #(
    parameter int NumWords  = 1024,
    parameter int DataWidth = 128,
    parameter int ByteWidth = 8,
    parameter int Latency   = 1,
    parameter int FifoDepth = 4,
    parameter int AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    parameter int CntWidth  = 16,
    localparam int BeWidth  = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [AddrWidth-1:0] base_addr_i,
    input  logic [AddrWidth-1:0] stride_i,
    input  logic [CntWidth-1:0]  num_words_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    output logic [BeWidth-1:0]   mem_be_o,
    input  logic [DataWidth-1:0] mem_rdata_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DataWidth-1:0] out_data_o
);
    localparam int PtrW  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int FCntW = $clog2(FifoDepth + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d, stride_q, stride_d;
    logic [CntWidth-1:0]  num_q, num_d, req_cnt_q, req_cnt_d, acc_cnt_q, acc_cnt_d;
    logic                 done_q, done_d;
    logic [Latency-1:0]   vld_q, vld_d;
    logic [DataWidth-1:0] fifo_mem [FifoDepth];
    logic [PtrW-1:0]      wptr_q, rptr_q;
    logic [FCntW-1:0]     fcnt_q;

    logic tail, fifo_empty, hs, bypass, push, pop;
    int   occ;

    assign tail       = vld_q[Latency-1];
    assign fifo_empty = (fcnt_q == '0);
    assign occ        = $countones(vld_q) + int'(fcnt_q);

    assign mem_req_o   = (state_q == ISSUE) && (occ < FifoDepth);
    assign mem_we_o    = 1'b0;
    assign mem_wdata_o = '0;
    assign mem_be_o    = '1;
    assign mem_addr_o  = addr_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;

    assign out_valid_o = !fifo_empty || tail;
    assign out_data_o  = !fifo_empty ? fifo_mem[rptr_q] : (tail ? mem_rdata_i : '0);
    assign hs          = out_valid_o && out_ready_i;
    // A word arriving into an empty FIFO while ready is consumed directly and never stored.
    assign bypass      = fifo_empty && tail && out_ready_i;
    assign push        = tail && !bypass;
    assign pop         = !fifo_empty && out_ready_i;
    assign vld_d       = (vld_q << 1) | Latency'(mem_req_o);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        stride_d  = stride_q;
        num_d     = num_q;
        req_cnt_d = req_cnt_q;
        acc_cnt_d = acc_cnt_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (num_words_i != '0) begin
                        addr_d    = base_addr_i;
                        stride_d  = stride_i;
                        num_d     = num_words_i;
                        req_cnt_d = '0;
                        acc_cnt_d = '0;
                        state_d   = ISSUE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (mem_req_o) begin
                    addr_d    = addr_q + stride_q;
                    req_cnt_d = req_cnt_q + CntWidth'(1);
                    if (req_cnt_q == num_q - CntWidth'(1)) state_d = DRAIN;
                end
                if (hs) acc_cnt_d = acc_cnt_q + CntWidth'(1);
            end
            DRAIN: begin
                if (hs) begin
                    acc_cnt_d = acc_cnt_q + CntWidth'(1);
                    if (acc_cnt_q == num_q - CntWidth'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            stride_q  <= '0;
            num_q     <= '0;
            req_cnt_q <= '0;
            acc_cnt_q <= '0;
            done_q    <= 1'b0;
            vld_q     <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            fcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            stride_q  <= stride_d;
            num_q     <= num_d;
            req_cnt_q <= req_cnt_d;
            acc_cnt_q <= acc_cnt_d;
            done_q    <= done_d;
            vld_q     <= vld_d;
            if (push) wptr_q <= (wptr_q == PtrW'(FifoDepth - 1)) ? '0 : wptr_q + PtrW'(1);
            if (pop)  rptr_q <= (rptr_q == PtrW'(FifoDepth - 1)) ? '0 : rptr_q + PtrW'(1);
            unique case ({push, pop})
                2'b10:   fcnt_q <= fcnt_q + FCntW'(1);
                2'b01:   fcnt_q <= fcnt_q - FCntW'(1);
                default: fcnt_q <= fcnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wptr_q] <= mem_rdata_i;
    end
endmodule
